// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - multi-port register file with bypass, pending scoreboard and clear engine
//
// Purpose: DEPTH x DATA_WIDTH register file with WRITE_PORTS write ports and
// READ_PORTS combinational read ports. It adds same-cycle write-to-read
// forwarding (BYPASS), a per-register pending bit set by load reservations
// and cleared by writes, an optional hard-wired zero register (ZERO_REG),
// and a sequential clear engine that zeroes one register per cycle.
//
// Ports:
//   clk_i            clock, rising edge
//   reset_ni         asynchronous active-low reset
//   writeSuppress_i  drops every external write and reserve this cycle
//   writeEnable_i    per-port write enable
//   writeAddress_i   per-port write address
//   writeData_i      per-port write data
//   reserveEnable_i  mark reserveAddress_i as pending
//   reserveAddress_i register to reserve
//   clearStart_i     start the sequential clear (ignored while clearing)
//   readAddress_i    per-port read address
//   readData_o       per-port read data (combinational)
//   readPending_o    per-port registered pending bit of the addressed register
//   clearBusy_o      clear engine active
module regfile_multiport #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter bit ZERO_REG    = 1'b0,
  parameter bit BYPASS      = 1'b1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_ni,
  input  logic                                   writeSuppress_i,
  input  logic [WRITE_PORTS-1:0]                 writeEnable_i,
  input  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] writeAddress_i,
  input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] writeData_i,
  input  logic                                   reserveEnable_i,
  input  logic [ADDR_WIDTH-1:0]                  reserveAddress_i,
  input  logic                                   clearStart_i,
  input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]  readAddress_i,
  output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  readData_o,
  output logic [READ_PORTS-1:0]                  readPending_o,
  output logic                                   clearBusy_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clear_ptr_q, clear_ptr_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [DEPTH];
  logic [DEPTH-1:0]        pending_q, pending_d;
  logic [WRITE_PORTS-1:0]  commit;
  logic                    reserve_ok;

  assign clearBusy_o = (state_q == CLEAR);

  // A write only counts (for storage, scoreboard and bypass) when it will
  // really land in the array.
  always_comb begin
    for (int i = 0; i < WRITE_PORTS; i++) begin
      commit[i] = writeEnable_i[i] && !writeSuppress_i && !clearBusy_o &&
                  !(ZERO_REG && (writeAddress_i[i] == '0));
    end
  end

  assign reserve_ok = reserveEnable_i && !writeSuppress_i && !clearBusy_o &&
                      !(ZERO_REG && (reserveAddress_i == '0));

  // Clear engine
  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    case (state_q)
      IDLE: begin
        if (clearStart_i) begin
          state_d     = CLEAR;
          clear_ptr_d = '0;
        end
      end
      CLEAR: begin
        clear_ptr_d = clear_ptr_q + ADDR_WIDTH'(1);
        if (clear_ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Array and scoreboard next state. Ports are applied in ascending order so
  // the highest-indexed port wins a collision; the reserve is applied after
  // the writes so a same-cycle write+reserve leaves the register pending.
  always_comb begin
    mem_d     = mem_q;
    pending_d = pending_q;
    for (int i = 0; i < WRITE_PORTS; i++) begin
      if (commit[i]) begin
        mem_d[writeAddress_i[i]]     = writeData_i[i];
        pending_d[writeAddress_i[i]] = 1'b0;
      end
    end
    if (reserve_ok) begin
      pending_d[reserveAddress_i] = 1'b1;
    end
    if (clearBusy_o) begin
      mem_d[clear_ptr_q]     = '0;
      pending_d[clear_ptr_q] = 1'b0;
    end
    if (ZERO_REG) begin
      mem_d[0]     = '0;
      pending_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      clear_ptr_q <= '0;
      pending_q   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      pending_q   <= pending_d;
      mem_q       <= mem_d;
    end
  end

  // Read ports. commit[] is already low while clearing or suppressed, so
  // those cycles never forward. The pending bit is deliberately not bypassed.
  always_comb begin
    for (int j = 0; j < READ_PORTS; j++) begin
      readData_o[j] = mem_q[readAddress_i[j]];
      if (BYPASS) begin
        for (int i = 0; i < WRITE_PORTS; i++) begin
          if (commit[i] && (writeAddress_i[i] == readAddress_i[j])) begin
            readData_o[j] = writeData_i[i];
          end
        end
      end
      if (ZERO_REG && (readAddress_i[j] == '0)) begin
        readData_o[j] = '0;
      end
      readPending_o[j] = pending_q[readAddress_i[j]];
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - self-checking bench for regfile_multiport
module tb_regfile_multiport;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int RP    = 2;
  localparam int WP    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [WP-1:0]         we;
  logic [WP-1:0][AW-1:0] wa;
  logic [WP-1:0][DW-1:0] wd;
  logic                  sup, re, cs;
  logic [AW-1:0]         ra;
  logic [RP-1:0][AW-1:0] rda;
  logic [RP-1:0][DW-1:0] rd_a, rd_b;
  logic [RP-1:0]         rp_a, rp_b;
  logic                  busy_a, busy_b;

  // Reference state: index 0 = dut_a (ZERO_REG=0, BYPASS=1),
  // index 1 = dut_b (ZERO_REG=1, BYPASS=0).
  logic [DW-1:0] m_mem  [2][DEPTH];
  bit            m_pend [2][DEPTH];
  int            clr_rem;
  int            n_assert, n_fail;
  int            busy_cnt;

  always #5 clk = ~clk;

  regfile_multiport #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP), .WRITE_PORTS(WP),
    .ZERO_REG(1'b0), .BYPASS(1'b1)
  ) dut_a (
    .clk_i(clk), .reset_ni(rst_n), .writeSuppress_i(sup),
    .writeEnable_i(we), .writeAddress_i(wa), .writeData_i(wd),
    .reserveEnable_i(re), .reserveAddress_i(ra), .clearStart_i(cs),
    .readAddress_i(rda), .readData_o(rd_a), .readPending_o(rp_a),
    .clearBusy_o(busy_a)
  );

  regfile_multiport #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP), .WRITE_PORTS(WP),
    .ZERO_REG(1'b1), .BYPASS(1'b0)
  ) dut_b (
    .clk_i(clk), .reset_ni(rst_n), .writeSuppress_i(sup),
    .writeEnable_i(we), .writeAddress_i(wa), .writeData_i(wd),
    .reserveEnable_i(re), .reserveAddress_i(ra), .clearStart_i(cs),
    .readAddress_i(rda), .readData_o(rd_b), .readPending_o(rp_b),
    .clearBusy_o(busy_b)
  );

  function automatic bit cfg_zr(int c);
    return c == 1;
  endfunction

  function automatic bit cfg_byp(int c);
    return c == 0;
  endfunction

  function automatic logic [DW-1:0] exp_data(int c, logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (cfg_zr(c) && a == 0) return '0;
    v = m_mem[c][a];
    if (cfg_byp(c) && clr_rem == 0 && !sup) begin
      for (int i = 0; i < WP; i++) begin
        if (we[i] && wa[i] == a) v = wd[i];
      end
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    for (int j = 0; j < RP; j++) begin
      chk($sformatf("data_a p%0d a%0d", j, rda[j]), rd_a[j], exp_data(0, rda[j]));
      chk($sformatf("data_b p%0d a%0d", j, rda[j]), rd_b[j], exp_data(1, rda[j]));
      chk($sformatf("pend_a p%0d a%0d", j, rda[j]), 32'(rp_a[j]), 32'(m_pend[0][rda[j]]));
      chk($sformatf("pend_b p%0d a%0d", j, rda[j]), 32'(rp_b[j]), 32'(m_pend[1][rda[j]]));
    end
    chk("busy_a", 32'(busy_a), 32'(clr_rem > 0));
    chk("busy_b", 32'(busy_b), 32'(clr_rem > 0));
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < DEPTH; k++) begin
        m_mem[c][k]  = '0;
        m_pend[c][k] = 1'b0;
      end
    end
    clr_rem = 0;
  endtask

  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      if (clr_rem > 0) begin
        m_mem[c][DEPTH - clr_rem]  = '0;
        m_pend[c][DEPTH - clr_rem] = 1'b0;
      end else if (!sup) begin
        for (int i = 0; i < WP; i++) begin
          if (we[i] && !(cfg_zr(c) && wa[i] == 0)) begin
            m_mem[c][wa[i]]  = wd[i];
            m_pend[c][wa[i]] = 1'b0;
          end
        end
        if (re && !(cfg_zr(c) && ra == 0)) m_pend[c][ra] = 1'b1;
      end
    end
    if (clr_rem > 0) clr_rem--;
    else if (cs) clr_rem = DEPTH;
  endtask

  // Inputs are set just after a rising edge; outputs are checked mid-cycle.
  task automatic step();
    #2;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we  = '0;
    sup = 1'b0;
    re  = 1'b0;
    cs  = 1'b0;
  endtask

  task automatic sweep();
    for (int k = 0; k < DEPTH / 2; k++) begin
      idle();
      rda[0] = AW'(2 * k);
      rda[1] = AW'(2 * k + 1);
      step();
    end
  endtask

  task automatic fill_ones();
    for (int k = 0; k < DEPTH / 2; k++) begin
      idle();
      we    = 2'b11;
      wa[0] = AW'(2 * k);
      wa[1] = AW'(2 * k + 1);
      wd[0] = 32'hFFFF_FFFF;
      wd[1] = 32'hFFFF_FFFF;
      step();
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    idle();
    wa = '0; wd = '0; ra = '0; rda = '0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sweep();

    // Two ports hit address 7 in the same cycle
    idle();
    we = 2'b11; wa[0] = 5'd7; wa[1] = 5'd7;
    wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222;
    rda[0] = 5'd7; rda[1] = 5'd8;
    #1;
    chk("byp_same_a", rd_a[0], 32'h2222_2222);
    chk("byp_same_b", rd_b[0], 32'h0);
    step();
    idle();
    #1;
    chk("byp_next_a", rd_a[0], 32'h2222_2222);
    chk("byp_next_b", rd_b[0], 32'h2222_2222);
    step();

    // Zero register
    idle();
    we = 2'b01; wa[0] = 5'd0; wd[0] = 32'hDEAD_BEEF;
    re = 1'b1; ra = 5'd0; rda[0] = 5'd0;
    step();
    idle();
    #1;
    chk("zr_data_a", rd_a[0], 32'hDEAD_BEEF);
    chk("zr_data_b", rd_b[0], 32'h0);
    chk("zr_pend_a", 32'(rp_a[0]), 32'd1);
    chk("zr_pend_b", 32'(rp_b[0]), 32'd0);
    step();

    // Reserve 12, three idle cycles, then the load returns
    idle();
    re = 1'b1; ra = 5'd12; rda[0] = 5'd12;
    step();
    for (int k = 1; k <= 3; k++) begin
      idle();
      #1;
      chk($sformatf("res12_c%0d", k), 32'(rp_a[0]), 32'd1);
      step();
    end
    idle();
    we = 2'b01; wa[0] = 5'd12; wd[0] = 32'h55;
    #1;
    chk("res12_c4", 32'(rp_a[0]), 32'd1);
    step();
    idle();
    #1;
    chk("res12_cleared", 32'(rp_a[0]), 32'd0);
    chk("res12_data_b", rd_b[0], 32'h55);
    step();
    idle();
    we = 2'b01; wa[0] = 5'd12; wd[0] = 32'h66; re = 1'b1; ra = 5'd12;
    step();
    idle();
    #1;
    chk("wr_res12_a", 32'(rp_a[0]), 32'd1);
    chk("wr_res12_b", 32'(rp_b[0]), 32'd1);
    step();

    // Suppressed write and reserve
    idle();
    sup = 1'b1; we = 2'b01; wa[0] = 5'd3; wd[0] = 32'hAA;
    re = 1'b1; ra = 5'd3; rda[0] = 5'd3;
    #1;
    chk("sup_nobyp", rd_a[0], 32'h0);
    step();
    idle();
    #1;
    chk("sup_data", rd_a[0], 32'h0);
    chk("sup_pend", 32'(rp_a[0]), 32'd0);
    step();

    // Full clear with a write attempted mid-clear
    fill_ones();
    idle();
    cs = 1'b1;
    step();
    busy_cnt = 0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      idle();
      if (k == 5) begin
        we = 2'b10; wa[1] = 5'd31; wd[1] = 32'h1234_5678;
      end
      rda[0] = 5'd31;
      rda[1] = AW'(k);
      #1;
      if (busy_a) busy_cnt++;
      step();
    end
    chk("clear_busy_cycles", 32'(busy_cnt), 32'd32);
    sweep();

    // Clear aborted by reset
    fill_ones();
    idle();
    cs = 1'b1;
    step();
    for (int k = 0; k < 10; k++) begin
      idle();
      step();
    end
    idle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_abort_busy", 32'(busy_a), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sweep();

    // Randomised traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      idle();
      we = 2'($urandom);
      for (int i = 0; i < WP; i++) begin
        wa[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
        wd[i] = $urandom;
      end
      sup = ($urandom_range(0, 9) == 0);
      re  = ($urandom_range(0, 3) == 0);
      ra  = AW'($urandom_range(0, 7));
      cs  = ($urandom_range(0, 99) == 0);
      for (int j = 0; j < RP; j++) begin
        rda[j] = ($urandom_range(0, 1) == 1) ? wa[$urandom_range(0, 1)] : AW'($urandom_range(0, 7));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
